// File: rtl/frame_ram_arbiter.sv
// Single-port frame RAM arbiter: round-robin display reads vs drawing writes, plus a
// full-frame clear engine present only when FRAME_RAM_CLEAR_EN is defined.
module frame_ram_arbiter #(
    parameter int ADDR_W    = 17,
    parameter int PIXEL_NUM = 76800
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic              rd_data,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_data,
    output logic              wr_ack,
    input  logic              clear_req,
    input  logic              clear_color,
    output logic              clear_busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wren,
    output logic              ram_d,
    input  logic              ram_q
);

    // One extra bit so PIXEL_NUM == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] PIXEL_LIM = (ADDR_W+1)'(PIXEL_NUM);

`ifdef FRAME_RAM_CLEAR_EN
    typedef enum logic [1:0] {IDLE, READ_WAIT, CLEAR} state_t;
    localparam logic [ADDR_W-1:0] PIXEL_LAST = ADDR_W'(PIXEL_NUM - 1);

    logic [ADDR_W-1:0] clear_cnt, clear_cnt_next;
    logic              clear_pending, clear_pending_next;
    logic              clear_color_q, clear_color_next;
    logic              clear_accept;
`else
    typedef enum logic [1:0] {IDLE, READ_WAIT} state_t;

    logic unused_clear_inputs;
    assign unused_clear_inputs = clear_req ^ clear_color;
`endif

    state_t state, state_next;
    logic   last_grant_wr, last_grant_wr_next;
    logic   rd_oob_q, rd_oob_next;
    logic   grant_rd, grant_wr;
    logic   rd_in_range, wr_in_range;

    assign rd_in_range = ({1'b0, rd_addr} < PIXEL_LIM);
    assign wr_in_range = ({1'b0, wr_addr} < PIXEL_LIM);

    // Read wins a tie only when the previous grant went to the writer.
    assign grant_rd = rd_req && (!wr_req || last_grant_wr);
    assign grant_wr = wr_req && !grant_rd;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            last_grant_wr <= 1'b1;
            rd_oob_q      <= 1'b0;
`ifdef FRAME_RAM_CLEAR_EN
            clear_cnt     <= '0;
            clear_pending <= 1'b0;
            clear_color_q <= 1'b0;
`endif
        end else begin
            state         <= state_next;
            last_grant_wr <= last_grant_wr_next;
            rd_oob_q      <= rd_oob_next;
`ifdef FRAME_RAM_CLEAR_EN
            clear_cnt     <= clear_cnt_next;
            clear_pending <= clear_pending_next;
            clear_color_q <= clear_color_next;
`endif
        end
    end

    always_comb begin
        state_next         = state;
        last_grant_wr_next = last_grant_wr;
        rd_oob_next        = rd_oob_q;
        ram_addr           = '0;
        ram_wren           = 1'b0;
        ram_d              = 1'b0;
        wr_ack             = 1'b0;
        rd_valid           = 1'b0;
        rd_data            = 1'b0;
        clear_busy         = 1'b0;
`ifdef FRAME_RAM_CLEAR_EN
        clear_cnt_next     = clear_cnt;
        clear_pending_next = clear_pending;
        clear_color_next   = clear_color_q;
        // A request while a clear is already pending or running is dropped outright.
        clear_accept       = clear_req && !clear_pending && (state != CLEAR);
        clear_busy         = clear_req || clear_pending || (state == CLEAR);
        if (clear_accept)
            clear_color_next = clear_color;
`endif

        case (state)
            IDLE: begin
`ifdef FRAME_RAM_CLEAR_EN
                if (clear_pending || clear_req) begin
                    state_next         = CLEAR;
                    clear_cnt_next     = '0;
                    clear_pending_next = 1'b0;
                end else
`endif
                if (grant_rd) begin
                    ram_addr           = rd_addr;
                    rd_oob_next        = !rd_in_range;
                    last_grant_wr_next = 1'b0;
                    state_next         = READ_WAIT;
                end else if (grant_wr) begin
                    ram_addr           = wr_addr;
                    ram_d              = wr_data;
                    ram_wren           = wr_in_range;
                    wr_ack             = 1'b1;
                    last_grant_wr_next = 1'b1;
                end
            end
            READ_WAIT: begin
                rd_valid   = 1'b1;
                rd_data    = rd_oob_q ? 1'b0 : ram_q;
                state_next = IDLE;
`ifdef FRAME_RAM_CLEAR_EN
                if (clear_accept)
                    clear_pending_next = 1'b1;
`endif
            end
`ifdef FRAME_RAM_CLEAR_EN
            CLEAR: begin
                ram_addr       = clear_cnt;
                ram_wren       = 1'b1;
                ram_d          = clear_color_q;
                clear_cnt_next = clear_cnt + 1'b1;
                if (clear_cnt == PIXEL_LAST)
                    state_next = IDLE;
            end
`endif
            default: state_next = IDLE;
        endcase

        // Outputs are held quiet for the whole time reset is low, not just after the edge.
        if (!reset) begin
            ram_addr   = '0;
            ram_wren   = 1'b0;
            ram_d      = 1'b0;
            wr_ack     = 1'b0;
            rd_valid   = 1'b0;
            rd_data    = 1'b0;
            clear_busy = 1'b0;
        end
    end

endmodule

// File: doc/frame_ram_arbiter.md
FRAME_RAM_ARBITER -- requirements
Module: frame_ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 17, frame RAM address width.
REQ-002 SHALL have parameter PIXEL_NUM, default 76800, number of valid pixel addresses (0..PIXEL_NUM-1).
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port rd_req  input  1  read request from the display reader; held high until rd_valid.
REQ-006 SHALL have port rd_addr  input  ADDR_W  read address; stable while rd_req is high.
REQ-007 SHALL have port rd_valid  output  1  one-cycle pulse; rd_data is valid.
REQ-008 SHALL have port rd_data  output  1  1-bit pixel read result.
REQ-009 SHALL have port wr_req  input  1  write request from the drawing writer; held high until wr_ack.
REQ-010 SHALL have port wr_addr  input  ADDR_W  write address; stable while wr_req is high.
REQ-011 SHALL have port wr_data  input  1  pixel value to write.
REQ-012 SHALL have port wr_ack  output  1  one-cycle pulse; the write is performed this cycle.
REQ-013 SHALL have port clear_req  input  1  one-cycle pulse requesting a full-frame fill.
REQ-014 SHALL have port clear_color  input  1  fill value, sampled on the clear_req cycle.
REQ-015 SHALL have port clear_busy  output  1  high while a clear is pending or running.
REQ-016 SHALL have port ram_addr  output  ADDR_W  single-port frame RAM address.
REQ-017 SHALL have port ram_wren  output  1  RAM write enable.
REQ-018 SHALL have port ram_d  output  1  RAM write data.
REQ-019 SHALL have port ram_q  input  1  RAM read data; registered RAM with 1-cycle read latency.

Function
REQ-020 SHALL implement FSM states IDLE, READ_WAIT, CLEAR; at most one RAM access per cycle.
REQ-021 In IDLE, priority SHALL be: clear (clear_pending or clear_req, CLEAR_EN builds only) > round-robin between rd_req and wr_req.
REQ-022 Round-robin SHALL grant the requester not granted last when both are pending; last_grant resets to write, so read wins the first tie.
REQ-023 Read grant in cycle N SHALL drive ram_addr=rd_addr and ram_wren=0, then enter READ_WAIT.
REQ-024 In READ_WAIT (cycle N+1), rd_valid=1 and rd_data=ram_q; the FSM returns to IDLE; the next grant is no earlier than N+2.
REQ-025 Write grant in cycle N SHALL drive ram_addr=wr_addr, ram_d=wr_data, ram_wren=1 and wr_ack=1 in the same cycle; the FSM stays in IDLE.
REQ-026 An address >= PIXEL_NUM SHALL be handled as follows: a write is acked with ram_wren=0; a read follows normal timing with rd_data=0.
REQ-027 A clear grant SHALL enter CLEAR with the counter at 0; each CLEAR cycle drives ram_addr=counter, ram_wren=1, ram_d=latched clear_color; the counter increments.
REQ-028 CLEAR SHALL last exactly PIXEL_NUM cycles; after address PIXEL_NUM-1 the FSM returns to IDLE.
REQ-029 clear_req arriving in READ_WAIT SHALL be latched and served at the next IDLE decision.
REQ-030 clear_req arriving while clear_busy is already high SHALL be ignored, with no restart and no colour change.
REQ-031 clear_busy SHALL be high from the clear_req cycle through the last CLEAR cycle, combinationally.
REQ-032 rd_req and wr_req arriving during CLEAR SHALL stall without being dropped, and SHALL be served after CLEAR.
REQ-033 When idle with no grant, ram_wren=0, wr_ack=0, rd_valid=0 and rd_data=0 SHALL hold.

Reset
REQ-034 While reset=0 at a clk edge, the block SHALL set state IDLE, clear counter 0, clear_pending 0 and last_grant write.
REQ-035 While reset=0, ram_wren, wr_ack, rd_valid, rd_data, clear_busy, ram_addr and ram_d SHALL be forced to 0.
REQ-036 Reset during CLEAR SHALL abort the clear; RAM stays partially filled; no request is remembered.

Configuration
REQ-037 Macro FRAME_RAM_CLEAR_EN defined: the clear engine (REQ-027..031) SHALL be present.
REQ-038 Macro FRAME_RAM_CLEAR_EN undefined: the CLEAR state and counter SHALL be absent, clear_req and clear_color ignored, and clear_busy tied 0.

Verification
REQ-039 Read of addr 5 holding 1, no contention -> ram_addr=5 at N; rd_valid=1, rd_data=1 at N+1; single pulse.
REQ-040 rd_req and wr_req both high from reset release -> read granted first, write acked at N+2, alternating thereafter.
REQ-041 Write addr 76800, data 1 -> wr_ack=1, ram_wren=0; a subsequent read of 76800 returns rd_data=0.
REQ-042 clear_req with clear_color=1 (CLEAR_EN) -> 76800 consecutive ram_wren cycles, addrs 0..76799, ram_d=1; clear_busy low after; a wr_req raised mid-clear is acked on the first IDLE cycle.
REQ-043 Reset=0 asserted at clear address 1000 -> next cycle all outputs 0 and state IDLE; a later read of addr 2000 returns the prior content.
REQ-044 Build without FRAME_RAM_CLEAR_EN, pulse clear_req -> clear_busy stays 0 and rd/wr servicing is unaffected.
